// File: rtl/unidade_mult_div.sv
// Iterative 16-bit unsigned multiply/divide unit: 16 compute cycles, then the
// 32-bit result is written back as two consecutive registers.
module unidade_mult_div #(
  parameter int unsigned LARGURA  = 16,
  parameter int unsigned ENDERECO = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inicio,
  input  logic                op,
  input  logic [LARGURA-1:0]  opA,
  input  logic [LARGURA-1:0]  opB,
  input  logic [ENDERECO-1:0] regDest,
  output logic                ocupado,
  output logic                pronto,
  output logic                div_zero,
  output logic [LARGURA-1:0]  dado,
  output logic [ENDERECO-1:0] regC,
  output logic                RW
);

  localparam int unsigned LD = 2 * LARGURA;
  localparam int unsigned LR = LARGURA + 1;
  localparam int unsigned CW = $clog2(LARGURA) + 1;

  typedef enum logic [1:0] {
    OCIOSO,
    CALCULA,
    ESCREVE_BAIXO,
    ESCREVE_ALTO
  } estado_t;

  estado_t estado, prox_estado;

  logic                op_q;
  logic [LARGURA-1:0]  opa_q;
  logic [LARGURA-1:0]  opb_q;
  logic [ENDERECO-1:0] regdest_q;
  logic [CW-1:0]       cont;
  logic [LD-1:0]       acc;
  logic [LR-1:0]       resto;

  logic [LARGURA-1:0]  addendo;
  logic [LR-1:0]       soma;
  logic [LR-1:0]       tentativa;
  logic                cabe;
  logic [LR-1:0]       resto_prox;
  logic [LD-1:0]       acc_prox;

  logic                ocupado_d;
  logic                pronto_d;
  logic                rw_d;
  logic [LARGURA-1:0]  dado_d;
  logic [ENDERECO-1:0] regc_d;

  // One iteration: multiply keeps {high, multiplier} in acc and shifts right;
  // divide keeps the dividend/quotient in acc's low half and shifts left.
  always_comb begin
    addendo    = acc[0] ? opa_q : '0;
    soma       = {1'b0, acc[LD-1:LARGURA]} + {1'b0, addendo};
    tentativa  = LR'({resto, acc[LARGURA-1]});
    cabe       = (tentativa >= {1'b0, opb_q});
    resto_prox = cabe ? (tentativa - {1'b0, opb_q}) : tentativa;
    if (op_q) begin
      acc_prox = {acc[LD-1:LARGURA], acc[LARGURA-2:0], cabe};
    end else begin
      acc_prox = {soma, acc[LARGURA-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    prox_estado = estado;
    dado_d      = dado;
    regc_d      = regC;
    case (estado)
      OCIOSO: begin
        if (inicio) prox_estado = CALCULA;
      end
      CALCULA: begin
        if (cont == CW'(LARGURA - 1)) begin
          prox_estado = ESCREVE_BAIXO;
          dado_d      = acc_prox[LARGURA-1:0];
          regc_d      = regdest_q;
        end
      end
      ESCREVE_BAIXO: begin
        prox_estado = ESCREVE_ALTO;
        dado_d      = op_q ? resto[LARGURA-1:0] : acc[LD-1:LARGURA];
        regc_d      = ENDERECO'(regdest_q + 1'b1);
      end
      ESCREVE_ALTO: begin
        prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
    ocupado_d = (prox_estado != OCIOSO);
    rw_d      = (prox_estado == ESCREVE_BAIXO) || (prox_estado == ESCREVE_ALTO);
    pronto_d  = (prox_estado == ESCREVE_ALTO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      regdest_q <= '0;
      cont      <= '0;
      acc       <= '0;
      resto     <= '0;
      div_zero  <= 1'b0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      RW        <= 1'b0;
      dado      <= '0;
      regC      <= '0;
    end else begin
      ocupado <= ocupado_d;
      pronto  <= pronto_d;
      RW      <= rw_d;
      dado    <= dado_d;
      regC    <= regc_d;
      if (estado == OCIOSO && inicio) begin
        op_q      <= op;
        opa_q     <= opA;
        opb_q     <= opB;
        regdest_q <= regDest;
        cont      <= '0;
        resto     <= '0;
        acc       <= {{LARGURA{1'b0}}, (op ? opA : opB)};
        div_zero  <= op & (opB == '0);
      end else if (estado == CALCULA) begin
        acc   <= acc_prox;
        resto <= resto_prox;
        cont  <= CW'(cont + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed-vector bench for unidade_mult_div: checks write-back timing,
// results, address wrap, divide-by-zero flag, overlap and reset aborts.
module tb_unidade_mult_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        inicio;
  logic        op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic [3:0]  regDest;
  logic        ocupado;
  logic        pronto;
  logic        div_zero;
  logic [15:0] dado;
  logic [3:0]  regC;
  logic        RW;

  int n_vec = 0;
  int n_err = 0;

  unidade_mult_div dut (
    .clk      (clk),
    .rst      (rst),
    .inicio   (inicio),
    .op       (op),
    .opA      (opA),
    .opB      (opB),
    .regDest  (regDest),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .div_zero (div_zero),
    .dado     (dado),
    .regC     (regC),
    .RW       (RW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ".ocupado"},  32'(ocupado),  32'd0);
    chk({nm, ".pronto"},   32'(pronto),   32'd0);
    chk({nm, ".div_zero"}, 32'(div_zero), 32'd0);
    chk({nm, ".RW"},       32'(RW),       32'd0);
    chk({nm, ".dado"},     32'(dado),     32'd0);
    chk({nm, ".regC"},     32'(regC),     32'd0);
  endtask

  // Full operation from start edge E0 through E18; optionally keeps inicio
  // high with junk operands the whole time.
  task automatic run_op(input string nm, input logic o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] rd,
                        input logic [15:0] lo, input logic [15:0] hi,
                        input logic dz, input bit hold);
    logic [3:0] rd_hi;
    rd_hi = rd + 4'd1;
    @(negedge clk);
    inicio = 1'b1; op = o; opA = a; opB = b; regDest = rd;
    @(posedge clk); #1;
    chk({nm, ".E0.ocupado"},  32'(ocupado),  32'd1);
    chk({nm, ".E0.div_zero"}, 32'(div_zero), 32'(dz));
    chk({nm, ".E0.RW"},       32'(RW),       32'd0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (hold) begin
        inicio = 1'b1; op = 1'($urandom); opA = 16'($urandom);
        opB = 16'($urandom); regDest = 4'($urandom);
      end else begin
        inicio = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 15) begin
        chk({nm, ".E15.RW"},      32'(RW),      32'd0);
        chk({nm, ".E15.ocupado"}, 32'(ocupado), 32'd1);
      end else if (c == 16) begin
        chk({nm, ".lo.RW"},     32'(RW),     32'd1);
        chk({nm, ".lo.regC"},   32'(regC),   32'(rd));
        chk({nm, ".lo.dado"},   32'(dado),   32'(lo));
        chk({nm, ".lo.pronto"}, 32'(pronto), 32'd0);
      end else if (c == 17) begin
        chk({nm, ".hi.RW"},     32'(RW),     32'd1);
        chk({nm, ".hi.regC"},   32'(regC),   32'(rd_hi));
        chk({nm, ".hi.dado"},   32'(dado),   32'(hi));
        chk({nm, ".hi.pronto"}, 32'(pronto), 32'd1);
      end else if (c == 18) begin
        chk({nm, ".E18.RW"},       32'(RW),       32'd0);
        chk({nm, ".E18.ocupado"},  32'(ocupado),  32'd0);
        chk({nm, ".E18.pronto"},   32'(pronto),   32'd0);
        chk({nm, ".E18.dado"},     32'(dado),     32'(hi));
        chk({nm, ".E18.div_zero"}, 32'(div_zero), 32'(dz));
      end
    end
  endtask

  // Start an op, assert reset #3 after edge E<at>, and confirm no write follows.
  task automatic reset_abort(input string nm, input int at, input logic o,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] rd);
    bit rw_seen;
    @(negedge clk);
    inicio = 1'b1; op = o; opA = a; opB = b; regDest = rd;
    @(posedge clk);
    @(negedge clk);
    inicio = 1'b0;
    repeat (at) @(posedge clk);
    #1;
    if (at == 16) chk({nm, ".pre.RW"}, 32'(RW), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs(nm);
    @(negedge clk);
    rst = 1'b0;
    rw_seen = 1'b0;
    for (int c = 0; c < 22; c++) begin
      @(posedge clk); #1;
      if (RW || ocupado) rw_seen = 1'b1;
    end
    chk({nm, ".no_write"}, 32'(rw_seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; inicio = 1'b0; op = 1'b0; opA = '0; opB = '0; regDest = '0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op("mul3x5",   1'b0, 16'd3,    16'd5,    4'd4,  16'h000F, 16'h0000, 1'b0, 1'b0);
    run_op("mulFFFF",  1'b0, 16'hFFFF, 16'hFFFF, 4'd2,  16'h0001, 16'hFFFE, 1'b0, 1'b0);
    run_op("div100_7", 1'b1, 16'd100,  16'd7,    4'd15, 16'd14,   16'd2,    1'b0, 1'b0);
    run_op("div0",     1'b1, 16'h1234, 16'h0000, 4'd6,  16'hFFFF, 16'h1234, 1'b1, 1'b0);
    run_op("mul9x9",   1'b0, 16'd9,    16'd9,    4'd7,  16'h0051, 16'h0000, 1'b0, 1'b0);
    run_op("ovl_div",  1'b1, 16'd1000, 16'd33,   4'd9,  16'd30,   16'd10,   1'b0, 1'b1);
    run_op("ovl_mul",  1'b0, 16'h00FF, 16'h0101, 4'd10, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

    reset_abort("rst_calc", 8,  1'b1, 16'h1234, 16'h0000, 4'd5);
    run_op("post_rst1", 1'b1, 16'hABCD, 16'h0010, 4'd3, 16'h0ABC, 16'h000D, 1'b0, 1'b0);
    reset_abort("rst_wlo", 16, 1'b0, 16'd200, 16'd300, 4'd8);
    run_op("post_rst2", 1'b0, 16'd200, 16'd300, 4'd8, 16'hEA60, 16'h0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
